// File: rtl/ma_output_checker.sv
// ma_output_checker: sink-side self-check for the MA filter stream.
// Delays the clean reference by the filter latency, compares it against the
// filtered output and produces a per-frame pass/fail verdict.
// Optional feature macro: MA_CHECK_SUM_EN adds the sum_abs_err accumulator port.
// Ports:
//   clk, rst          clock, async active-high reset
//   start             1-cycle pulse that arms a new frame (honoured in IDLE/DONE)
//   in_valid          filtered_data/original_data valid this cycle
//   filtered_data     filter output sample
//   original_data     clean reference sample, same cycle as the filter input
//   busy              frame in progress (WARMUP or CHECK)
//   frame_done        1-cycle pulse when the frame completes
//   pass              verdict, valid from frame_done until the next start
//   err_cnt           out-of-tolerance samples in the frame (saturating)
//   max_err           largest |error| in the frame
//   sample_cnt        samples compared in the frame
//   sum_abs_err       running sum of |error| (MA_CHECK_SUM_EN only)
module ma_output_checker #(
    parameter int N         = 16,
    parameter int LATENCY   = 4,
    parameter int TOL       = 64,
    parameter int FRAME_LEN = 95,
    parameter int CNT_W     = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [N-1:0]     filtered_data,
    input  logic [N-1:0]     original_data,
    output logic             busy,
    output logic             frame_done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [N-1:0]     max_err,
    output logic [CNT_W-1:0] sample_cnt
`ifdef MA_CHECK_SUM_EN
    ,
    output logic [N+CNT_W-1:0] sum_abs_err
`endif
);
    localparam int FW = $clog2(LATENCY + 1);
    typedef enum logic [1:0] {IDLE, WARMUP, CHECK, DONE} state_t;
    state_t state, state_n;
    logic [N-1:0]     dly [LATENCY];
    logic [FW-1:0]    fill;
    logic [N:0]       diff, neg;
    logic [N-1:0]     err;
    logic [CNT_W-1:0] err_cnt_n;
    logic             shift, cmp, last, warm_last, go;
    // Oldest delay-line entry is the reference that lines up with this filter output
    assign diff      = {1'b0, filtered_data} - {1'b0, dly[LATENCY-1]};
    assign neg       = -diff;
    assign err       = diff[N] ? neg[N-1:0] : diff[N-1:0];
    assign shift     = in_valid && (state == WARMUP || state == CHECK);
    assign cmp       = in_valid && state == CHECK;
    assign last      = cmp && sample_cnt == CNT_W'(FRAME_LEN - 1);
    assign warm_last = in_valid && state == WARMUP && fill == FW'(LATENCY - 1);
    assign go        = start && (state == IDLE || state == DONE);
    assign err_cnt_n = (err > N'(TOL) && err_cnt != '1) ? err_cnt + 1'b1 : err_cnt;
    always_comb begin
        state_n = state;
        busy    = state == WARMUP || state == CHECK;
        state_n = go ? WARMUP : warm_last ? CHECK : last ? DONE : state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            dly        <= '{default: '0};
            fill       <= '0;
            frame_done <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            max_err    <= '0;
            sample_cnt <= '0;
        end else begin
            state      <= state_n;
            frame_done <= last;
            if (shift) begin
                dly[0] <= original_data;
                for (int i = 1; i < LATENCY; i++) dly[i] <= dly[i-1];
            end
            if (go) begin
                fill       <= '0;
                pass       <= 1'b0;
                err_cnt    <= '0;
                max_err    <= '0;
                sample_cnt <= '0;
            end else begin
                if (in_valid && state == WARMUP) fill <= fill + 1'b1;
                if (cmp) begin
                    sample_cnt <= sample_cnt + 1'b1;
                    err_cnt    <= err_cnt_n;
                    max_err    <= err > max_err ? err : max_err;
                end
                if (last) pass <= err_cnt_n == '0;
            end
        end
    end
`ifdef MA_CHECK_SUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sum_abs_err <= '0;
        else if (go) sum_abs_err <= '0;
        else if (cmp) sum_abs_err <= sum_abs_err + (N + CNT_W)'(err);
    end
`endif
endmodule
